bcd_scan_counter: RTL and testbench
===================================

// Module: bcd_scan_counter
// PURPOSE
//   Multi-digit synchronous BCD up/down counter with load and clear, plus a
//   time-multiplexed digit scanner. Sits directly upstream of the per-segment
//   seven-segment decoders (segment A..G): scan_bcd[3:0] drives their 4-bit digit
//   input, bit 3 = in1 (MSB) ... bit 0 = in4. Digit codes 10-15 are never emitted.
// PARAMETERS
//   NDIGITS   4    number of BCD digits (1..8); digit 0 = least significant
//   SCAN_DIV  16   clock cycles each digit stays selected on the scan port (>=1)
// PORTS
//   clk        in   1           single clock, rising edge
//   rst_n      in   1           asynchronous, active-low reset
//   clr        in   1           synchronous clear of all digits to 0
//   load       in   1           synchronous parallel load from load_val
//   load_val   in   4*NDIGITS   BCD load value, digit i at [4i+3:4i]
//   en         in   1           count enable (one step per cycle while high)
//   up         in   1           1 = increment, 0 = decrement
//   count      out  4*NDIGITS   registered counter value, digit i at [4i+3:4i]
//   carry      out  1           1-cycle pulse on wrap (9..9 -> 0..0 or 0..0 -> 9..9)
//   scan_sel   out  NDIGITS     one-hot digit strobe for the display
//   scan_bcd   out  4           BCD code of the strobed digit, to segment decoders
// BEHAVIOUR
//   - Reset (rst_n=0, async): count=0, carry=0, scan_sel=1 (digit 0), scan_bcd=0,
//     scan divider=0. Reset mid-count or mid-scan discards all state immediately.
//   - Priority per cycle: clr > load > en. clr or load with en=1: no count step, carry=0.
//   - load: each nibble of load_val > 9 is stored as 0; legal nibbles stored as-is.
//   - Increment: digit 0 +1; a digit at 9 becomes 0 and passes carry to the next
//     digit in the same cycle (full ripple, result visible next cycle).
//   - Decrement: digit 0 -1; a digit at 0 becomes 9 and borrows from the next digit.
//   - Wrap: all-9 + up -> all-0; all-0 + down -> all-9; carry=1 for exactly the cycle
//     after that edge, else 0. en=0 holds count and forces carry=0.
//   - Counting latency 1 cycle: count reflects controls sampled at the previous edge.
//   - Scanner free-runs independently of en/clr/load: divider counts 0..SCAN_DIV-1;
//     when it is SCAN_DIV-1 the selected index advances, NDIGITS-1 wraps to 0.
//     SCAN_DIV=1 advances every cycle.
//   - scan_sel is one-hot of the index; scan_bcd is registered and equals the digit
//     of count (post-update value) at the index that scan_sel shows in the same cycle,
//     so the pair is always coherent; scan_bcd is always 0..9.
//   - NDIGITS=1: scan_sel is constant 1, scan_bcd tracks count.
// STRUCTURE
//   - Shared package: BCD_W=4, BCD_MAX=4'd9, BCD_MIN=4'd0, and a function
//     bcd_sanitize(nibble) returning 0 for codes 10-15.
//   - Sub-module bcd_digit: one digit register with clr/load/en/up/cin inputs,
//     digit and cout (carry/borrow) outputs; instantiated NDIGITS times via generate,
//     cout of digit i -> cin of digit i+1; cin of digit 0 = en.
//   - Top holds wrap detection, carry register, scan divider, index, output mux.
// TESTING
//   - NDIGITS=4: load 16'h0009, en=1 up=1, one cycle -> count=16'h0010, carry=0.
//   - load 16'h9999, en=1 up=1 -> count=16'h0000, carry=1 one cycle, then 0.
//   - load 16'h0000, en=1 up=0 -> count=16'h9999, carry=1; next -> 16'h9998, carry=0.
//   - load 16'hA5F3 -> count=16'h0503; clr=1 load=1 en=1 together -> count=0, carry=0.
//   - SCAN_DIV=2, count=16'h4321 held: scan_sel 0001,0001,0010,0010,0100,0100,1000,
//     1000,0001 with scan_bcd 1,1,2,2,3,3,4,4,1; scan_bcd never >9 (assertion).
//   - Counting mid-scan, drop rst_n for 1 cycle -> same-cycle count=0, carry=0,
//     scan_sel=0001, scan_bcd=0; resumes from 0 after release.

Source files
------------

// File: rtl/bcd_scan_counter_pkg.sv
// Shared BCD types, limits and helpers for the BCD scan counter.
// Imported by the digit cell, the interface, the top and the checker.
package bcd_scan_counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;
  localparam logic [BCD_W-1:0] BCD_MIN = 4'd0;

  typedef logic [BCD_W-1:0] bcd_t;

  // Illegal codes 10-15 collapse to 0 so nothing downstream ever sees them.
  function automatic bcd_t bcd_sanitize(input bcd_t nibble);
    bcd_t res;
    if (nibble > BCD_MAX) begin
      res = BCD_MIN;
    end else begin
      res = nibble;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_scan_counter_if.sv
// Control / status bundle between a counter client (master) and the
// BCD scan counter (slave).
interface bcd_scan_counter_if #(
  parameter int NDIGITS = 4
);
  import bcd_scan_counter_pkg::*;

  logic                     clr;
  logic                     load;
  logic [BCD_W*NDIGITS-1:0] load_val;
  logic                     en;
  logic                     up;
  logic [BCD_W*NDIGITS-1:0] count;
  logic                     carry;
  logic [NDIGITS-1:0]       scan_sel;
  logic [BCD_W-1:0]         scan_bcd;

  modport master (
    output clr, load, load_val, en, up,
    input  count, carry, scan_sel, scan_bcd
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output count, carry, scan_sel, scan_bcd
  );

endinterface

// File: rtl/bcd_scan_counter_chk.sv
// Invariant checks for the BCD scan counter outputs; no functional logic.
module bcd_scan_counter_chk
  import bcd_scan_counter_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic [BCD_W*NDIGITS-1:0] count,
  input logic [NDIGITS-1:0]       scan_sel,
  input logic [BCD_W-1:0]         scan_bcd
);

  a_scan_bcd_legal: assert property (@(posedge clk) disable iff (!rst_n)
    scan_bcd <= BCD_MAX);

  a_scan_sel_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot(scan_sel));

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit_chk
    a_count_digit_legal: assert property (@(posedge clk) disable iff (!rst_n)
      count[BCD_W*g +: BCD_W] <= BCD_MAX);
  end

endmodule

// File: rtl/bcd_scan_counter_digit.sv
// One BCD digit of the ripple counter: clear > load > step, with a
// carry/borrow out that feeds the next more significant digit.
module bcd_digit
  import bcd_scan_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic load,
  input  bcd_t load_digit,
  input  logic up,
  input  logic cin,
  output bcd_t digit,
  output bcd_t digit_nxt,
  output logic cout
);

  bcd_t digit_r;
  bcd_t digit_nxt_s;
  logic cout_s;

  // Next digit value and carry/borrow toward the next digit.
  always_comb begin
    digit_nxt_s = digit_r;
    cout_s      = 1'b0;
    if (cin) begin
      if (up) begin
        cout_s = (digit_r == BCD_MAX);
      end else begin
        cout_s = (digit_r == BCD_MIN);
      end
    end else begin
      cout_s = 1'b0;
    end
    if (clr) begin
      digit_nxt_s = BCD_MIN;
    end else if (load) begin
      digit_nxt_s = bcd_sanitize(load_digit);
    end else if (cin) begin
      if (up) begin
        if (digit_r == BCD_MAX) begin
          digit_nxt_s = BCD_MIN;
        end else begin
          digit_nxt_s = digit_r + 4'd1;
        end
      end else begin
        if (digit_r == BCD_MIN) begin
          digit_nxt_s = BCD_MAX;
        end else begin
          digit_nxt_s = digit_r - 4'd1;
        end
      end
    end else begin
      digit_nxt_s = digit_r;
    end
  end

  // Digit state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_r <= BCD_MIN;
    end else begin
      digit_r <= digit_nxt_s;
    end
  end

  assign digit     = digit_r;
  assign digit_nxt = digit_nxt_s;
  assign cout      = cout_s;

endmodule

// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with wrap pulse and a free-running digit
// scanner whose strobe and digit code are registered together.
module bcd_scan_counter
  import bcd_scan_counter_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int SCAN_DIV = 16
) (
  input logic               clk,
  input logic               rst_n,
  bcd_scan_counter_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  bcd_t               digit_s [NDIGITS];
  bcd_t               nxt_s   [NDIGITS];
  logic [NDIGITS:0]   chain_s;
  logic               wrap_s;
  logic               carry_r;
  logic [DIV_W-1:0]   div_r;
  logic [DIV_W-1:0]   div_nxt_s;
  logic [IDX_W-1:0]   idx_r;
  logic [IDX_W-1:0]   idx_nxt_s;
  logic [NDIGITS-1:0] sel_nxt_s;
  logic [NDIGITS-1:0] scan_sel_r;
  bcd_t               bcd_nxt_s;
  bcd_t               scan_bcd_r;

  assign chain_s[0] = bus.en;

  for (genvar g = 0; g < NDIGITS; g++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst_n      (rst_n),
      .clr        (bus.clr),
      .load       (bus.load),
      .load_digit (bus.load_val[BCD_W*g +: BCD_W]),
      .up         (bus.up),
      .cin        (chain_s[g]),
      .digit      (digit_s[g]),
      .digit_nxt  (nxt_s[g]),
      .cout       (chain_s[g+1])
    );
    assign bus.count[BCD_W*g +: BCD_W] = digit_s[g];
  end

  // A wrap only counts when the step actually happens (clr/load win).
  assign wrap_s = chain_s[NDIGITS] & ~bus.clr & ~bus.load;

  // Scanner next state plus the strobe/code pair for the next cycle.
  always_comb begin
    div_nxt_s = div_r;
    idx_nxt_s = idx_r;
    sel_nxt_s = '0;
    bcd_nxt_s = BCD_MIN;
    if (div_r == DIV_W'(SCAN_DIV - 1)) begin
      div_nxt_s = '0;
      if (idx_r == IDX_W'(NDIGITS - 1)) begin
        idx_nxt_s = '0;
      end else begin
        idx_nxt_s = idx_r + 1'b1;
      end
    end else begin
      div_nxt_s = div_r + 1'b1;
      idx_nxt_s = idx_r;
    end
    // Pair the new index with the post-update digit so strobe and code agree.
    for (int i = 0; i < NDIGITS; i++) begin
      if (idx_nxt_s == IDX_W'(i)) begin
        sel_nxt_s[i] = 1'b1;
        bcd_nxt_s    = bcd_sanitize(nxt_s[i]);
      end else begin
        sel_nxt_s[i] = 1'b0;
      end
    end
  end

  // Wrap pulse, scan divider, scan index and registered scan outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_r    <= 1'b0;
      div_r      <= '0;
      idx_r      <= '0;
      scan_sel_r <= NDIGITS'(1);
      scan_bcd_r <= BCD_MIN;
    end else begin
      carry_r    <= wrap_s;
      div_r      <= div_nxt_s;
      idx_r      <= idx_nxt_s;
      scan_sel_r <= sel_nxt_s;
      scan_bcd_r <= bcd_nxt_s;
    end
  end

  assign bus.carry    = carry_r;
  assign bus.scan_sel = scan_sel_r;
  assign bus.scan_bcd = scan_bcd_r;

  bcd_scan_counter_chk #(.NDIGITS(NDIGITS)) u_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .count    (bus.count),
    .scan_sel (bus.scan_sel),
    .scan_bcd (bus.scan_bcd)
  );

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Scoreboard bench for bcd_scan_counter (NDIGITS=4, SCAN_DIV=2): an integer
// reference model pushes expected outputs per edge, each test pops and compares.
module tb_bcd_scan_counter;

  localparam int ND   = 4;
  localparam int SDIV = 2;
  localparam int MOD  = 10000;

  typedef struct packed {
    logic [15:0] count;
    logic        carry;
    logic [3:0]  sel;
    logic [3:0]  bcd;
  } exp_t;

  logic clk;
  logic rst_n;
  exp_t sb_q[$];
  int   m_cnt;
  int   m_k;
  int   n_vec;
  int   n_bad;

  bcd_scan_counter_if #(.NDIGITS(ND)) bus ();

  bcd_scan_counter #(.NDIGITS(ND), .SCAN_DIV(SDIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int p10(input int e);
    int r;
    r = 1;
    for (int i = 0; i < e; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[4*i +: 4] = 4'((v / p10(i)) % 10);
    return r;
  endfunction

  function automatic int load_to_int(input logic [15:0] v);
    int r;
    int d;
    r = 0;
    for (int i = 0; i < ND; i++) begin
      d = int'(v[4*i +: 4]);
      if (d > 9) d = 0;
      r = r + d * p10(i);
    end
    return r;
  endfunction

  // Drive one cycle of controls, advance the model and queue the expectation.
  task automatic apply(input logic c, input logic l, input logic [15:0] v,
                       input logic e, input logic u);
    exp_t x;
    int   old;
    int   idx;
    bus.clr = c; bus.load = l; bus.load_val = v; bus.en = e; bus.up = u;
    @(posedge clk);
    old     = m_cnt;
    x.carry = 1'b0;
    if (c) m_cnt = 0;
    else if (l) m_cnt = load_to_int(v);
    else if (e && u) begin
      x.carry = (old == MOD - 1);
      m_cnt   = (old + 1) % MOD;
    end else if (e) begin
      x.carry = (old == 0);
      m_cnt   = (old + MOD - 1) % MOD;
    end
    m_k++;
    idx     = (m_k / SDIV) % ND;
    x.count = to_bcd(m_cnt);
    x.sel   = 4'b0001 << idx;
    x.bcd   = 4'((m_cnt / p10(idx)) % 10);
    sb_q.push_back(x);
    #1;
  endtask

  task automatic test_reset;
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = 16'h0; bus.en = 1'b0; bus.up = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== {16'h0, 1'b0, 4'b0001, 4'd0}) begin
      n_bad++;
      $display("FAIL reset: got count=%h carry=%b sel=%b bcd=%0d want 0000/0/0001/0",
               bus.count, bus.carry, bus.scan_sel, bus.scan_bcd);
    end
    rst_n = 1'b1;
    m_cnt = 0; m_k = 0;
    sb_q.delete();
  endtask

  task automatic test_increment;
    exp_t x;
    apply(1'b0, 1'b1, 16'h0009, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    x = sb_q.pop_front();
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h0010, 1'b0}) begin
      n_bad++;
      $display("FAIL inc_ripple: got %h/%b want 0010/0", bus.count, bus.carry);
    end
    for (int i = 0; i < 12; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      x = sb_q.pop_front();
      n_vec++;
      if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== x) begin
        n_bad++;
        $display("FAIL inc_step%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, bus.count,
                 bus.carry, bus.scan_sel, bus.scan_bcd, x.count, x.carry, x.sel, x.bcd);
      end
    end
  endtask

  task automatic test_wrap_up;
    apply(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h0000, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_up: got %h/%b want 0000/1", bus.count, bus.carry);
    end
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h0001, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_up_after: got %h/%b want 0001/0", bus.count, bus.carry);
    end
  endtask

  task automatic test_wrap_down;
    apply(1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h9999, 1'b1}) begin
      n_bad++;
      $display("FAIL wrap_down: got %h/%b want 9999/1", bus.count, bus.carry);
    end
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h9998, 1'b0}) begin
      n_bad++;
      $display("FAIL wrap_down_after: got %h/%b want 9998/0", bus.count, bus.carry);
    end
    apply(1'b0, 1'b1, 16'h1000, 1'b0, 1'b0);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h0999, 1'b0}) begin
      n_bad++;
      $display("FAIL borrow_ripple: got %h/%b want 0999/0", bus.count, bus.carry);
    end
  endtask

  task automatic test_load_clr;
    apply(1'b0, 1'b1, 16'hA5F3, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    n_vec++;
    if (bus.count !== 16'h0503) begin
      n_bad++;
      $display("FAIL load_sanitize: got %h want 0503", bus.count);
    end
    apply(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h9999, 1'b0}) begin
      n_bad++;
      $display("FAIL load_over_en: got %h/%b want 9999/0", bus.count, bus.carry);
    end
    apply(1'b1, 1'b1, 16'h1234, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    n_vec++;
    if ({bus.count, bus.carry} !== {16'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL clr_priority: got %h/%b want 0000/0", bus.count, bus.carry);
    end
  endtask

  task automatic test_scan;
    exp_t x;
    apply(1'b0, 1'b1, 16'h4321, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      x = sb_q.pop_front();
      n_vec++;
      if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== x || bus.scan_bcd > 4'd9) begin
        n_bad++;
        $display("FAIL scan%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, bus.count,
                 bus.carry, bus.scan_sel, bus.scan_bcd, x.count, x.carry, x.sel, x.bcd);
      end
    end
  endtask

  task automatic test_back_to_back;
    exp_t        x;
    logic [15:0] v;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       v = 16'h9999;
        1:       v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      apply(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), v,
            ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
      x = sb_q.pop_front();
      n_vec++;
      if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== x) begin
        n_bad++;
        $display("FAIL b2b%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, bus.count,
                 bus.carry, bus.scan_sel, bus.scan_bcd, x.count, x.carry, x.sel, x.bcd);
      end
    end
  endtask

  task automatic test_reset_mid;
    exp_t x;
    apply(1'b0, 1'b1, 16'h9999, 1'b0, 1'b1);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    void'(sb_q.pop_front());
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== {16'h0, 1'b0, 4'b0001, 4'd0}) begin
      n_bad++;
      $display("FAIL reset_mid: got count=%h carry=%b sel=%b bcd=%0d want 0000/0/0001/0",
               bus.count, bus.carry, bus.scan_sel, bus.scan_bcd);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    m_cnt = 0; m_k = 0;
    sb_q.delete();
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      x = sb_q.pop_front();
      n_vec++;
      if ({bus.count, bus.carry, bus.scan_sel, bus.scan_bcd} !== x) begin
        n_bad++;
        $display("FAIL resume%0d: got %h/%b/%b/%0d want %h/%b/%b/%0d", i, bus.count,
                 bus.carry, bus.scan_sel, bus.scan_bcd, x.count, x.carry, x.sel, x.bcd);
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    test_reset();
    test_increment();
    test_wrap_up();
    test_wrap_down();
    test_load_clr();
    test_scan();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
